// File: rtl/in_cond_pkg.sv
// Shared types for the In1 input conditioner: debounce FSM state encoding and glitch counter width.
package in_cond_pkg;

  typedef enum logic [1:0] {
    LOW    = 2'b00,
    Q_RISE = 2'b01,
    HIGH   = 2'b10,
    Q_FALL = 2'b11
  } db_state_e;

  localparam int GLITCH_W = 8;

endpackage

// File: rtl/in_sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous single-bit input into the CLK domain.
module in_sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) chain <= '0;
    else      chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/in1_debounce_sync.sv
// Synchronises and debounces raw_in into a clean level plus edge strobes for the In1 detector.
// Optional abort counter on glitch_cnt is built when IN_COND_GLITCH_CNT_EN is defined.
module in1_debounce_sync
  import in_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw_in,
  input  logic sample_en,
  output logic clean_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic stable
`ifdef IN_COND_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  localparam int CNT_W = $clog2(DB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic            s;
  db_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic            clean_nxt, rise_nxt, fall_nxt;

  in_sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (raw_in),
    .q   (s)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= LOW;
      cnt        <= '0;
      clean_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      clean_out  <= clean_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
    end
  end

  // The first disagreeing sample counts as sample 1, so qualification takes DB_CYCLES samples.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clean_nxt = clean_out;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    if (sample_en) begin
      case (state)
        LOW: begin
          if (s) begin
            state_nxt = Q_RISE;
            cnt_nxt   = CNT_W'(1);
          end
        end
        Q_RISE: begin
          if (!s) begin
            state_nxt = LOW;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = HIGH;
            cnt_nxt   = '0;
            clean_nxt = 1'b1;
            rise_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        HIGH: begin
          if (!s) begin
            state_nxt = Q_FALL;
            cnt_nxt   = CNT_W'(1);
          end
        end
        Q_FALL: begin
          if (s) begin
            state_nxt = HIGH;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = LOW;
            cnt_nxt   = '0;
            clean_nxt = 1'b0;
            fall_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    stable = (state == LOW) || (state == HIGH);
  end

`ifdef IN_COND_GLITCH_CNT_EN
  logic                abort;
  logic [GLITCH_W-1:0] glitch_q;

  assign abort = sample_en &&
                 (((state == Q_RISE) && (state_nxt == LOW)) ||
                  ((state == Q_FALL) && (state_nxt == HIGH)));

  // Saturating; only reset clears it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                          glitch_q <= '0;
    else if (abort && (glitch_q != '1)) glitch_q <= glitch_q + 1'b1;
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_in1_debounce_sync.sv
// Directed bench for in1_debounce_sync at SYNC_STAGES=2, DB_CYCLES=4.
module tb_in1_debounce_sync;

  logic CLK = 1'b0;
  logic RST;
  logic raw_in;
  logic sample_en;
  logic clean_out, rise_pulse, fall_pulse, stable;
`ifdef IN_COND_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  in1_debounce_sync #(.SYNC_STAGES(2), .DB_CYCLES(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .raw_in     (raw_in),
    .sample_en  (sample_en),
    .clean_out  (clean_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .stable     (stable)
`ifdef IN_COND_GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0; raw_in = 1'b1; sample_en = 1'b1;
    repeat (3) tick();
    n_cmp++; if (clean_out !== 1'b0) begin n_bad++; $display("FAIL reset_clean got %b want 0", clean_out); end
    n_cmp++; if (rise_pulse !== 1'b0 || fall_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulses got %b%b want 00", rise_pulse, fall_pulse); end
    n_cmp++; if (stable !== 1'b1) begin n_bad++; $display("FAIL reset_stable got %b want 1", stable); end
`ifdef IN_COND_GLITCH_CNT_EN
    n_cmp++; if (glitch_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_glitch got %0d want 0", glitch_cnt); end
`endif
    RST = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      n_cmp++;
      if (clean_out !== (k >= 6) || rise_pulse !== (k == 6)) begin
        n_bad++;
        $display("FAIL post_reset_rise edge %0d got clean=%b rise=%b want clean=%b rise=%b",
                 k, clean_out, rise_pulse, (k >= 6), (k == 6));
      end
    end
  endtask

  task automatic test_fall();
    raw_in = 1'b0; sample_en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_cmp++;
      if (clean_out !== (k < 6) || fall_pulse !== (k == 6) || rise_pulse !== 1'b0 ||
          stable !== !(k >= 3 && k <= 5)) begin
        n_bad++;
        $display("FAIL fall edge %0d got clean=%b fall=%b rise=%b stable=%b want clean=%b fall=%b rise=0 stable=%b",
                 k, clean_out, fall_pulse, rise_pulse, stable, (k < 6), (k == 6), !(k >= 3 && k <= 5));
      end
    end
  endtask

  task automatic test_rise();
    raw_in = 1'b1; sample_en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_cmp++;
      if (clean_out !== (k >= 6) || rise_pulse !== (k == 6) || fall_pulse !== 1'b0 ||
          stable !== !(k >= 3 && k <= 5)) begin
        n_bad++;
        $display("FAIL rise edge %0d got clean=%b rise=%b fall=%b stable=%b want clean=%b rise=%b fall=0 stable=%b",
                 k, clean_out, rise_pulse, fall_pulse, stable, (k >= 6), (k == 6), !(k >= 3 && k <= 5));
      end
    end
  endtask

  task automatic test_glitch();
    sample_en = 1'b1;
    raw_in = 1'b1;
    repeat (3) tick();
    raw_in = 1'b0;
    for (int k = 4; k <= 10; k++) begin
      tick();
      n_cmp++;
      if (clean_out !== 1'b0 || rise_pulse !== 1'b0) begin
        n_bad++;
        $display("FAIL glitch edge %0d got clean=%b rise=%b want 0 0", k, clean_out, rise_pulse);
      end
    end
    n_cmp++; if (stable !== 1'b1) begin n_bad++; $display("FAIL glitch_stable got %b want 1", stable); end
`ifdef IN_COND_GLITCH_CNT_EN
    n_cmp++; if (glitch_cnt !== 8'd1) begin n_bad++; $display("FAIL glitch_cnt got %0d want 1", glitch_cnt); end
`endif
  endtask

  task automatic test_sample_en();
    raw_in = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      sample_en = (k % 2 == 1);
      tick();
      n_cmp++;
      if (clean_out !== (k >= 9) || rise_pulse !== (k == 9) || stable !== !(k >= 3 && k <= 8)) begin
        n_bad++;
        $display("FAIL sample_en edge %0d got clean=%b rise=%b stable=%b want clean=%b rise=%b stable=%b",
                 k, clean_out, rise_pulse, stable, (k >= 9), (k == 9), !(k >= 3 && k <= 8));
      end
    end
    sample_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    raw_in = 1'b1; sample_en = 1'b1;
    repeat (4) tick();
    n_cmp++; if (stable !== 1'b0) begin n_bad++; $display("FAIL mid_qualify_stable got %b want 0", stable); end
    RST = 1'b0;
    #1;
    n_cmp++; if (stable !== 1'b1 || clean_out !== 1'b0) begin n_bad++; $display("FAIL mid_reset got stable=%b clean=%b want 1 0", stable, clean_out); end
`ifdef IN_COND_GLITCH_CNT_EN
    n_cmp++; if (glitch_cnt !== 8'd0) begin n_bad++; $display("FAIL mid_reset_glitch got %0d want 0", glitch_cnt); end
`endif
    repeat (2) tick();
    RST = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      n_cmp++;
      if (clean_out !== (k >= 6) || rise_pulse !== (k == 6)) begin
        n_bad++;
        $display("FAIL requalify edge %0d got clean=%b rise=%b want clean=%b rise=%b",
                 k, clean_out, rise_pulse, (k >= 6), (k == 6));
      end
    end
  endtask

  initial begin
    RST = 1'b0; raw_in = 1'b0; sample_en = 1'b0;
    #2;
    test_reset();
    test_fall();
    test_rise();
    test_fall();
    test_glitch();
    test_sample_en();
    test_fall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
